pixel_stream_packer: RTL
========================

// Module: pixel_stream_packer
// PURPOSE
//  Packs a byte stream from the SD reader into RGB565 pixels for the framebuffer writer.
//  Supports multiple source formats, frame/line counting and valid/ready back-pressure.
//  Sits between the SD sector reader and the framebuffer write port.
// PARAMETERS
//  LINE_PIXELS  320  pixels per line; 1..4095
//  FRAME_LINES  240  lines per frame; 1..4095
//  OUT_W        16   output pixel width; fixed at 16 (RGB565), other values are illegal
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  start        in   1   1-cycle pulse: latch fmt, clear counters, drop any partial pixel
//  fmt          in   2   0=RGB888 (R,G,B) 1=BGR888 (B,G,R) 2=RGB565 LE (lo,hi) 3=GRAY8
//  in_data      in   8   source byte
//  in_valid     in   1   in_data valid
//  in_ready     out  1   byte accepted when in_valid&&in_ready
//  pixel_data   out  16  RGB565 pixel
//  pixel_valid  out  1   pixel_data valid; held until accepted
//  pixel_ready  in   1   downstream accept
//  pixel_last   out  1   qualifies the last pixel of each line
//  frame_done   out  1   1-cycle pulse on acceptance of the final pixel of the frame
//  busy         out  1   high from start until frame_done
// BEHAVIOUR
//  Reset: in_ready=0, pixel_data=0, pixel_valid=0, pixel_last=0, frame_done=0, busy=0.
//   Counters are cleared and fmt_q=0.
//  States:
//   IDLE: in_ready=0. start -> COLLECT.
//   COLLECT: bytes are accepted; byte_idx counts 0..bpp-1 (bpp=3,3,2,1 for fmt 0..3).
//    The last byte loads the output register in the same cycle.
//   PAD: see ROW_PAD_SKIP_EN.
//   IDLE is re-entered on the frame_done cycle.
//  in_ready = busy && (!pixel_valid || pixel_ready): single output register, no bubble.
//   A completing byte accepted in the same cycle as a pixel handshake overwrites the register;
//   pixel_valid stays 1.
//  Conversion: RGB888 {r[7:3],g[7:2],b[7:3]}; RGB565 {hi,lo}; GRAY8 {y[7:3],y[7:2],y[7:3]}.
//  Latency: last byte of a pixel accepted in cycle N -> pixel_valid in cycle N+1.
//  Counters:
//   x_cnt advances when a pixel is accepted downstream; it wraps at LINE_PIXELS-1 and
//    increments y_cnt.
//   pixel_last = pixel_valid && x_cnt==LINE_PIXELS-1.
//   Frame end: y_cnt==FRAME_LINES-1 and last pixel accepted -> frame_done=1 for 1 cycle,
//    busy=0, IDLE.
//  start while busy: restart. Partial bytes and the held pixel are discarded (pixel_valid=0),
//   counters are cleared, the new fmt is latched. start has priority over any handshake that cycle.
//  fmt changes while busy: ignored until the next start.
//  in_valid while IDLE: ignored, not consumed.
// CONFIGURATION
//  ROW_PAD_SKIP_EN defined:
//   After the last byte of each line, PAD consumes pad=(4-(LINE_PIXELS*bpp)%4)%4 bytes
//    with in_ready=1 and no output (BMP row alignment).
//   pad==0 skips PAD.
//   The pad count is computed at start from the latched fmt.
//   After the final line's padding, the frame completes.
//  ROW_PAD_SKIP_EN undefined: PAD state absent; the byte stream is contiguous.
// STRUCTURE
//  Package pixel_fmt_pkg: fmt codes (FMT_RGB888, FMT_BGR888, FMT_RGB565, FMT_GRAY8),
//   state encodings, bpp lookup function, rgb888_to_rgb565 function.
//  Sub-module pixel_fmt_convert: combinational byte-assembly -> RGB565 from fmt_q and
//   captured bytes. All sequencing stays in the top module.
// TESTING
//  1. fmt=0, LINE_PIXELS=2, FRAME_LINES=1, bytes FF,00,00,00,FF,00 -> F800 then 07E0;
//     pixel_last on 2nd; frame_done 1 cycle.
//  2. fmt=2 bytes 34,12 -> pixel_data 1234. fmt=3 byte 80 -> 8410. fmt=1 bytes 00,00,FF -> F800.
//  3. pixel_ready=0 for 5 cycles with pixel_valid=1 -> in_ready=0, pixel_data stable;
//     release -> no lost or duplicated pixel over 100 random-stall pixels.
//  4. ROW_PAD_SKIP_EN, fmt=0, LINE_PIXELS=3 -> 9 data bytes then 3 pad bytes consumed silently;
//     next line's first pixel correct.
//  5. start after 1 of 3 bytes -> partial dropped; next 3 bytes form pixel 0 with x_cnt=0.
//  6. reset_n low mid-frame with pixel_valid=1 -> all outputs 0 asynchronously;
//     IDLE after release, in_valid ignored until start.

Source files
------------

// File: rtl/pixel_fmt_pkg.sv
// -----------------------------------------------------------------------------
// pixel_fmt_pkg
// Shared definitions for the pixel stream packer:
//   - source format codes carried on the 2-bit fmt port
//   - packer FSM state encoding (ST_PAD exists only when ROW_PAD_SKIP_EN is defined)
//   - bytes-per-pixel lookup, RGB888 -> RGB565 reduction, BMP row pad calculation
// No ports (package).
// -----------------------------------------------------------------------------
package pixel_fmt_pkg;

    typedef enum logic [1:0] {
        FMT_RGB888 = 2'd0,
        FMT_BGR888 = 2'd1,
        FMT_RGB565 = 2'd2,
        FMT_GRAY8  = 2'd3
    } pix_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1
`ifdef ROW_PAD_SKIP_EN
        ,
        ST_PAD     = 2'd2
`endif
    } pack_state_e;

    localparam int PIX_W = 16;
    localparam int CNT_W = 12;

    // Source bytes that make up one pixel for each format.
    function automatic logic [1:0] fmt_bpp(input pix_fmt_e f);
        logic [1:0] bpp;
        case (f)
            FMT_RGB888: bpp = 2'd3;
            FMT_BGR888: bpp = 2'd3;
            FMT_RGB565: bpp = 2'd2;
            FMT_GRAY8:  bpp = 2'd1;
            default:    bpp = 2'd1;
        endcase
        return bpp;
    endfunction

    // Truncating reduction of 8-bit channels to 5/6/5.
    function automatic logic [15:0] rgb888_to_rgb565(input logic [7:0] r,
                                                     input logic [7:0] g,
                                                     input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // Pad bytes needed to round a source row up to a multiple of 4 bytes.
    function automatic logic [1:0] row_pad_bytes(input int unsigned line_pixels,
                                                 input logic [1:0]  bpp);
        int unsigned rem;
        rem = (line_pixels * {30'd0, bpp}) % 32'd4;
        return 2'((32'd4 - rem) % 32'd4);
    endfunction

endpackage

// File: rtl/pixel_fmt_convert.sv
// -----------------------------------------------------------------------------
// pixel_fmt_convert
// Combinational assembly of one RGB565 pixel from the bytes of a source pixel.
// The final byte of the pixel is taken straight from the input bus so the
// output register can be loaded in the same cycle that byte is accepted.
// Ports:
//   fmt        in  latched source format
//   byte0      in  first captured byte of the pixel
//   byte1      in  second captured byte of the pixel
//   last_byte  in  byte completing the pixel (bpp-th byte)
//   pixel      out RGB565 result
// -----------------------------------------------------------------------------
module pixel_fmt_convert
    import pixel_fmt_pkg::*;
(
    input  pix_fmt_e    fmt,
    input  logic [7:0]  byte0,
    input  logic [7:0]  byte1,
    input  logic [7:0]  last_byte,
    output logic [15:0] pixel
);

    // Select channel order per format and reduce to 5/6/5.
    always_comb begin
        pixel = 16'd0;
        case (fmt)
            FMT_RGB888: pixel = rgb888_to_rgb565(byte0, byte1, last_byte);
            FMT_BGR888: pixel = rgb888_to_rgb565(last_byte, byte1, byte0);
            FMT_RGB565: pixel = {last_byte, byte0};   // little-endian: lo then hi
            FMT_GRAY8:  pixel = rgb888_to_rgb565(last_byte, last_byte, last_byte);
            default:    pixel = 16'd0;
        endcase
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// -----------------------------------------------------------------------------
// pixel_stream_packer
// Packs a byte stream from the SD reader into RGB565 pixels for the
// framebuffer writer, with line/frame counting and valid/ready flow control.
// Optional feature macro: ROW_PAD_SKIP_EN -- consume BMP row padding bytes
// after each source line without producing output.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          pulse: latch fmt, clear counters, drop partial/held pixel
//   fmt            0=RGB888 1=BGR888 2=RGB565 LE 3=GRAY8
//   in_data/in_valid/in_ready        source byte stream
//   pixel_data/pixel_valid/pixel_ready  RGB565 output stream
//   pixel_last     last pixel of a line
//   frame_done     one-cycle pulse after the final pixel of the frame
//   busy           high from start until frame_done
// -----------------------------------------------------------------------------
module pixel_stream_packer
    import pixel_fmt_pkg::*;
#(
    parameter int LINE_PIXELS = 320,
    parameter int FRAME_LINES = 240,
    parameter int OUT_W       = 16      // must be 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       fmt,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] pixel_data,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic             pixel_last,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(LINE_PIXELS - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(FRAME_LINES - 1);

    pack_state_e      state_r, state_nxt_s;
    pix_fmt_e         fmt_r, fmt_nxt_s;
    logic [1:0]       byte_idx_r, byte_idx_nxt_s;
    logic [7:0]       byte0_r, byte0_nxt_s;
    logic [7:0]       byte1_r, byte1_nxt_s;
    logic [OUT_W-1:0] pixel_data_r, pixel_data_nxt_s;
    logic             pixel_valid_r, pixel_valid_nxt_s;
    logic             pixel_last_r, pixel_last_nxt_s;
    logic             frame_done_r, frame_done_nxt_s;
    logic             busy_r, busy_nxt_s;
    // Output side counts accepted pixels, input side counts assembled pixels.
    logic [CNT_W-1:0] x_cnt_r, x_cnt_nxt_s;
    logic [CNT_W-1:0] y_cnt_r, y_cnt_nxt_s;
    logic [CNT_W-1:0] in_x_r, in_x_nxt_s;
    logic [CNT_W-1:0] in_y_r, in_y_nxt_s;
    logic             in_done_r, in_done_nxt_s;     // every pixel of the frame assembled
    logic             out_done_r, out_done_nxt_s;   // final pixel of the frame accepted
`ifdef ROW_PAD_SKIP_EN
    logic [1:0]       pad_len_r, pad_len_nxt_s;
    logic [1:0]       pad_cnt_r, pad_cnt_nxt_s;
`endif

    logic [1:0]  bpp_s;
    logic [15:0] conv_s;
    logic        in_ready_s;
    logic        byte_acc_s;
    logic        pix_acc_s;

    pixel_fmt_convert u_convert (
        .fmt       (fmt_r),
        .byte0     (byte0_r),
        .byte1     (byte1_r),
        .last_byte (in_data),
        .pixel     (conv_s)
    );

    assign bpp_s = fmt_bpp(fmt_r);

    // Byte acceptance: one output register, so a byte may only enter when the
    // register is empty or being drained this cycle. start wins over any
    // handshake, so ready is withheld in the start cycle. Pad bytes never
    // touch the output register and are taken regardless of back-pressure.
    always_comb begin
`ifdef ROW_PAD_SKIP_EN
        if (state_r == ST_PAD) begin
            in_ready_s = busy_r && !start;
        end else begin
            in_ready_s = busy_r && !start && !in_done_r && (!pixel_valid_r || pixel_ready);
        end
`else
        in_ready_s = busy_r && !start && !in_done_r && (!pixel_valid_r || pixel_ready);
`endif
    end

    assign byte_acc_s = in_valid && in_ready_s;
    assign pix_acc_s  = pixel_valid_r && pixel_ready;

    // Next-state, counters and output-register loading.
    always_comb begin
        state_nxt_s       = state_r;
        fmt_nxt_s         = fmt_r;
        byte_idx_nxt_s    = byte_idx_r;
        byte0_nxt_s       = byte0_r;
        byte1_nxt_s       = byte1_r;
        pixel_data_nxt_s  = pixel_data_r;
        pixel_valid_nxt_s = pixel_valid_r;
        frame_done_nxt_s  = 1'b0;
        busy_nxt_s        = busy_r;
        x_cnt_nxt_s       = x_cnt_r;
        y_cnt_nxt_s       = y_cnt_r;
        in_x_nxt_s        = in_x_r;
        in_y_nxt_s        = in_y_r;
        in_done_nxt_s     = in_done_r;
        out_done_nxt_s    = out_done_r;
`ifdef ROW_PAD_SKIP_EN
        pad_len_nxt_s     = pad_len_r;
        pad_cnt_nxt_s     = pad_cnt_r;
`endif

        if (start) begin
            state_nxt_s       = ST_COLLECT;
            fmt_nxt_s         = pix_fmt_e'(fmt);
            byte_idx_nxt_s    = 2'd0;
            pixel_valid_nxt_s = 1'b0;
            busy_nxt_s        = 1'b1;
            x_cnt_nxt_s       = '0;
            y_cnt_nxt_s       = '0;
            in_x_nxt_s        = '0;
            in_y_nxt_s        = '0;
            in_done_nxt_s     = 1'b0;
            out_done_nxt_s    = 1'b0;
`ifdef ROW_PAD_SKIP_EN
            pad_len_nxt_s     = row_pad_bytes(LINE_PIXELS, fmt_bpp(pix_fmt_e'(fmt)));
            pad_cnt_nxt_s     = 2'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    // Downstream handshake first so a same-cycle reload keeps valid high.
                    if (pix_acc_s) begin
                        pixel_valid_nxt_s = 1'b0;
                        if (x_cnt_r == X_LAST) begin
                            x_cnt_nxt_s = '0;
                            if (y_cnt_r == Y_LAST) begin
                                out_done_nxt_s = 1'b1;
                            end else begin
                                y_cnt_nxt_s = y_cnt_r + CNT_W'(1);
                            end
                        end else begin
                            x_cnt_nxt_s = x_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        pixel_valid_nxt_s = pixel_valid_r;
                    end

                    if ((state_r == ST_COLLECT) && byte_acc_s) begin
                        if (byte_idx_r == (bpp_s - 2'd1)) begin
                            pixel_data_nxt_s  = conv_s;
                            pixel_valid_nxt_s = 1'b1;
                            byte_idx_nxt_s    = 2'd0;
                            if (in_x_r == X_LAST) begin
                                in_x_nxt_s = '0;
                                if (in_y_r == Y_LAST) begin
                                    in_done_nxt_s = 1'b1;
                                end else begin
                                    in_y_nxt_s = in_y_r + CNT_W'(1);
                                end
`ifdef ROW_PAD_SKIP_EN
                                if (pad_len_r != 2'd0) begin
                                    state_nxt_s   = ST_PAD;
                                    pad_cnt_nxt_s = 2'd0;
                                end else begin
                                    state_nxt_s   = ST_COLLECT;
                                end
`endif
                            end else begin
                                in_x_nxt_s = in_x_r + CNT_W'(1);
                            end
                        end else begin
                            if (byte_idx_r == 2'd0) begin
                                byte0_nxt_s = in_data;
                            end else begin
                                byte1_nxt_s = in_data;
                            end
                            byte_idx_nxt_s = byte_idx_r + 2'd1;
                        end
                    end else begin
                        byte_idx_nxt_s = byte_idx_r;
                    end

`ifdef ROW_PAD_SKIP_EN
                    if ((state_r == ST_PAD) && byte_acc_s) begin
                        if (pad_cnt_r == (pad_len_r - 2'd1)) begin
                            state_nxt_s = ST_COLLECT;
                        end else begin
                            pad_cnt_nxt_s = pad_cnt_r + 2'd1;
                        end
                    end else begin
                        pad_cnt_nxt_s = pad_cnt_nxt_s;
                    end
`endif

                    // Frame completes once the last pixel is taken and no
                    // trailing pad bytes remain.
                    if (out_done_nxt_s && (state_nxt_s == ST_COLLECT)) begin
                        frame_done_nxt_s = 1'b1;
                        busy_nxt_s       = 1'b0;
                        state_nxt_s      = ST_IDLE;
                    end else begin
                        frame_done_nxt_s = 1'b0;
                    end
                end
            endcase
        end

        pixel_last_nxt_s = pixel_valid_nxt_s && (x_cnt_nxt_s == X_LAST);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            fmt_r         <= FMT_RGB888;
            byte_idx_r    <= 2'd0;
            byte0_r       <= 8'd0;
            byte1_r       <= 8'd0;
            pixel_data_r  <= '0;
            pixel_valid_r <= 1'b0;
            pixel_last_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            x_cnt_r       <= '0;
            y_cnt_r       <= '0;
            in_x_r        <= '0;
            in_y_r        <= '0;
            in_done_r     <= 1'b0;
            out_done_r    <= 1'b0;
`ifdef ROW_PAD_SKIP_EN
            pad_len_r     <= 2'd0;
            pad_cnt_r     <= 2'd0;
`endif
        end else begin
            state_r       <= state_nxt_s;
            fmt_r         <= fmt_nxt_s;
            byte_idx_r    <= byte_idx_nxt_s;
            byte0_r       <= byte0_nxt_s;
            byte1_r       <= byte1_nxt_s;
            pixel_data_r  <= pixel_data_nxt_s;
            pixel_valid_r <= pixel_valid_nxt_s;
            pixel_last_r  <= pixel_last_nxt_s;
            frame_done_r  <= frame_done_nxt_s;
            busy_r        <= busy_nxt_s;
            x_cnt_r       <= x_cnt_nxt_s;
            y_cnt_r       <= y_cnt_nxt_s;
            in_x_r        <= in_x_nxt_s;
            in_y_r        <= in_y_nxt_s;
            in_done_r     <= in_done_nxt_s;
            out_done_r    <= out_done_nxt_s;
`ifdef ROW_PAD_SKIP_EN
            pad_len_r     <= pad_len_nxt_s;
            pad_cnt_r     <= pad_cnt_nxt_s;
`endif
        end
    end

    assign in_ready    = in_ready_s;
    assign pixel_data  = pixel_data_r;
    assign pixel_valid = pixel_valid_r;
    assign pixel_last  = pixel_last_r;
    assign frame_done  = frame_done_r;
    assign busy        = busy_r;

endmodule
